// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache, 8 sets of 32-byte lines.
//
// Hits are answered combinationally in the same cycle. A miss latches the
// line address and moves to FETCH, which holds a line-fill request until the
// memory side answers. The fill is written at the pmem_resp edge and the
// retried fetch then hits.
//
// Optional feature: define ICACHE_DM_PERF_EN to build the hit/miss
// performance counters. Without it, both counter ports read 0 and no
// counter flops exist.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   inst_read     fetch request
//   inst_addr     fetch byte address (bits [1:0] ignored)
//   inst_resp     inst_rdata valid this cycle (hit)
//   inst_rdata    fetched instruction word
//   pmem_read     line-fill request, held during FETCH
//   pmem_address  line-aligned fill address
//   pmem_rdata    returned 256-bit line, word w at [32w+31:32w]
//   pmem_resp     pmem_rdata valid for one cycle
//   hit_count     hits counted (0 unless ICACHE_DM_PERF_EN)
//   miss_count    IDLE->FETCH transitions (0 unless ICACHE_DM_PERF_EN)
//   state_dbg     FSM state for observation: 0 = IDLE, 1 = FETCH
//
// Handshake: pmem_read rises the cycle after a miss and stays high with a
// constant pmem_address until the cycle in which pmem_resp is sampled high;
// pmem_resp outside FETCH carries no meaning and is ignored.
module icache_dm (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic         inst_resp,
  output logic [31:0]  inst_rdata,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic         state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t       state_q;
  logic         pmem_read_q;
  logic [26:0]  line_addr_q;   // latched addr[31:5]
  logic [7:0]   valid_q;
  logic [23:0]  tag_q  [8];
  logic [255:0] data_q [8];

  logic [2:0]   req_index;
  logic [23:0]  req_tag;
  logic [2:0]   word_sel;
  logic         hit;
  logic         miss;
  logic         fill;
  logic [2:0]   fill_index;
  logic         unused_addr_bits;

  assign req_index        = inst_addr[7:5];
  assign req_tag          = inst_addr[31:8];
  assign word_sel         = inst_addr[4:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  assign hit  = (state_q == IDLE) && inst_read && valid_q[req_index] &&
                (tag_q[req_index] == req_tag);
  assign miss = (state_q == IDLE) && inst_read && !hit;
  assign fill = (state_q == FETCH) && pmem_resp;
  assign fill_index = line_addr_q[2:0];

  assign inst_resp    = hit;
  assign inst_rdata   = data_q[req_index][{word_sel, 5'b0} +: 32];
  assign pmem_read    = pmem_read_q;
  assign pmem_address = {line_addr_q, 5'b0};
  assign state_dbg    = (state_q == FETCH);

  // Control state, valid bits and latched fill address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pmem_read_q <= 1'b0;
      line_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            line_addr_q <= inst_addr[31:5];
            pmem_read_q <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            valid_q[fill_index] <= 1'b1;
            pmem_read_q         <= 1'b0;
            state_q             <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          pmem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_index]  <= line_addr_q[26:3];
      data_q[fill_index] <= pmem_rdata;
    end
  end

`ifdef ICACHE_DM_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: reset state, cold miss, table of hits and
// idle cycles, set conflict, stray pmem_resp in IDLE, reset mid-fill,
// address change mid-fill and (with ICACHE_DM_PERF_EN) counter behaviour.
module tb_icache_dm;

  logic         clk;
  logic         rst;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic         inst_resp;
  logic [31:0]  inst_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic         state_dbg;

  int checks;
  int errors;

  icache_dm dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Word contents of each line; the 0x60 line carries 0x13 in words 0 and 3.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
    logic [31:0] v;
    if (line == 32'h60 && (w == 0 || w == 3)) v = 32'h0000_0013;
    else v = 32'hC0DE_0000 ^ (line | (w << 2));
    return v;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] line);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(line, w);
    return l;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string name, input logic [31:0] exp_hit,
                                input logic [31:0] exp_miss);
`ifdef ICACHE_DM_PERF_EN
    chk({name, "_hit_count"}, hit_count, exp_hit);
    chk({name, "_miss_count"}, miss_count, exp_miss);
`else
    chk({name, "_hit_count"}, hit_count, 32'd0);
    chk({name, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Present a request in IDLE that must miss; leaves the DUT in FETCH.
  task automatic req_miss(input logic [31:0] addr);
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = addr;
    #2;
    chk("miss_resp", {31'd0, inst_resp}, 32'd0);
    chk("miss_pmem_read_idle", {31'd0, pmem_read}, 32'd0);
    @(posedge clk);
  endtask

  // Serve a FETCH of 'line' answering in the lat-th FETCH cycle.
  task automatic serve(input logic [31:0] line, input int lat);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      #2;
      chk("fetch_pmem_read", {31'd0, pmem_read}, 32'd1);
      chk("fetch_pmem_address", pmem_address, line);
      chk("fetch_resp", {31'd0, inst_resp}, 32'd0);
      chk("fetch_state", {31'd0, state_dbg}, 32'd1);
      if (c == lat) begin
        pmem_rdata = make_line(line);
        pmem_resp  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  // Present a request that must hit in the same cycle.
  task automatic req_hit(input logic [31:0] addr);
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = addr;
    #2;
    chk("hit_resp", {31'd0, inst_resp}, 32'd1);
    chk("hit_rdata", inst_rdata, mem_word({addr[31:5], 5'b0}, int'(addr[4:2])));
    chk("hit_pmem_read", {31'd0, pmem_read}, 32'd0);
    @(posedge clk);
  endtask

  task automatic do_miss(input logic [31:0] addr, input int lat);
    req_miss(addr);
    serve({addr[31:5], 5'b0}, lat);
    req_hit(addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 32'h64, 1'b1, mem_word(32'h60, 1)};
    vecs[1] = '{1'b1, 32'h68, 1'b1, mem_word(32'h60, 2)};
    vecs[2] = '{1'b1, 32'h7C, 1'b1, mem_word(32'h60, 7)};
    vecs[3] = '{1'b1, 32'h6D, 1'b1, 32'h0000_0013};
    vecs[4] = '{1'b0, 32'h60, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h80, 1'b0, 32'h0};

    rst        = 1'b0;
    inst_read  = 1'b0;
    inst_addr  = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", {31'd0, inst_resp}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    check_counters("rst", 32'd0, 32'd0);
    rst = 1'b1;

    // Cold miss on 0x60, memory answers in the third FETCH cycle
    do_miss(32'h60, 3);

    // Hits and idle cycles from the table
    foreach (vecs[i]) begin
      @(negedge clk);
      inst_read = vecs[i].rd;
      inst_addr = vecs[i].addr;
      #2;
      chk($sformatf("vec%0d_resp", i), {31'd0, inst_resp}, {31'd0, vecs[i].exp_resp});
      if (vecs[i].exp_resp)
        chk($sformatf("vec%0d_rdata", i), inst_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pmem_read", i), {31'd0, pmem_read}, 32'd0);
      @(posedge clk);
      if (i == 1) begin
        @(negedge clk);
        inst_read = 1'b0;
        #2;
        check_counters("seq", 32'd3, 32'd1);
      end
    end

    // Conflict in set 3: 0x160 evicts 0x60, then 0x60 misses again
    do_miss(32'h160, 2);
    do_miss(32'h60, 1);

    // Stray pmem_resp in IDLE must not touch storage or state
    @(negedge clk);
    inst_read  = 1'b0;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    pmem_resp  = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    chk("stray_state", {31'd0, state_dbg}, 32'd0);
    chk("stray_pmem_read", {31'd0, pmem_read}, 32'd0);
    req_hit(32'h60);

    // Reset asserted mid-FETCH abandons the fill
    req_miss(32'hE0);
    @(negedge clk);
    #2;
    chk("rstf_pmem_read_before", {31'd0, pmem_read}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstf_pmem_read_async", {31'd0, pmem_read}, 32'd0);
    chk("rstf_state_async", {31'd0, state_dbg}, 32'd0);
    inst_read  = 1'b0;
    pmem_rdata = make_line(32'hE0);
    pmem_resp  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    chk("rstf_pmem_read_after", {31'd0, pmem_read}, 32'd0);
    do_miss(32'h60, 2);
    do_miss(32'hE0, 1);

    // Address change mid-FETCH: fill lands at 0x80, 0xA0 then misses
    req_miss(32'h80);
    @(negedge clk);
    inst_addr = 32'hA0;
    serve(32'h80, 2);
    req_miss(32'hA0);
    serve(32'hA0, 1);
    req_hit(32'hA4);
    req_hit(32'h84);

`ifdef ICACHE_DM_PERF_EN
    // Counter wrap: preload hit counter to all-ones, one hit wraps to 0
    @(negedge clk);
    inst_read = 1'b0;
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    req_hit(32'h88);
    @(negedge clk);
    inst_read = 1'b0;
    #2;
    chk("wrap_hit_count", hit_count, 32'd0);
`else
    @(negedge clk);
    inst_read = 1'b0;
    #2;
    check_counters("end", 32'd0, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
